icache_param: RTL and testbench

ICACHE_PARAM -- requirements
Module: icache_param

---
 rtl/icache_pkg.sv | 8 +
 rtl/icache_data_ram.sv | 30 +++
 rtl/icache_param.sv | 143 ++++++++++++++
 tb/tb_icache_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default geometry for the instruction cache
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, REPLAY} state_t;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;
  localparam int LINES_DEF  = 16;
  localparam int WORDS_DEF  = 16;
endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: DEPTH x DATA_W array, one write port, one synchronous read port
//   clk/rst_n : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates the cycle after re and holds otherwise
module icache_data_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/icache_param.sv
// icache_param: direct-mapped instruction cache with line refill, redirect and invalidate
//   clk/rst_n        : clock, async active-low reset
//   req/addr         : sequential fetch; jmp/jmp_addr redirect overrides addr
//   dout/dout_valid  : fetched word, valid one cycle after a hit
//   stall            : fetch not accepted this cycle
//   mem_req/mem_addr/mem_ack/mem_data : word-at-a-time refill interface
//   inv/inv_addr/flush : invalidate one line / all lines
module icache_param
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINES  = LINES_DEF,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              flush
);
  localparam int WB    = $clog2(WORDS);
  localparam int LB    = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - WB - LB;
  localparam int LA_W  = ADDR_W - 2 - WB;
  state_t            state_q, state_d;
  logic [WB-1:0]     cnt_q, cnt_d;
  logic [LA_W-1:0]   line_q, line_d;
  logic [LINES-1:0]  valid_q, valid_d, pinv_q, pinv_d;
  logic              pjmp_q, pjmp_d, dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [TAG_W-1:0]  tags [LINES];
  logic [ADDR_W-1:0] fa;
  logic [WB-1:0]     f_word;
  logic [LB-1:0]     f_idx, inv_idx, r_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [LINES-1:0]  inv_mask;
  logic              lookup, hit, fill, last, unused_bits;
  // A redirect that arrived while busy (or a redirect that missed) stays pending
  // until its own lookup hits, so the refill replay fetches the redirect target.
  assign fa          = jmp ? jmp_addr : (pjmp_q ? paddr_q : addr);
  assign f_word      = fa[2 +: WB];
  assign f_idx       = fa[2+WB +: LB];
  assign f_tag       = fa[ADDR_W-1 -: TAG_W];
  assign inv_idx     = inv_addr[2+WB +: LB];
  assign r_idx       = line_q[LB-1:0];
  assign inv_mask    = flush ? '1 : (inv ? ({{(LINES-1){1'b0}}, 1'b1} << inv_idx) : '0);
  assign lookup      = (state_q == IDLE) && (req || jmp || pjmp_q);
  // A line being invalidated this cycle must not hit.
  assign hit         = valid_q[f_idx] && (tags[f_idx] == f_tag) && !inv_mask[f_idx];
  assign fill        = (state_q == REFILL) && mem_ack;
  assign last        = fill && (&cnt_q);
  assign stall       = (state_q != IDLE) || (lookup && !hit);
  assign mem_req     = state_q == REFILL;
  assign mem_addr    = {line_q, cnt_q, 2'b00};
  assign dout_valid  = dout_valid_q;
  assign unused_bits = ^{fa[1:0], inv_addr[ADDR_W-1:2+WB+LB], inv_addr[1+WB:0]};
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    valid_d      = valid_q;
    pinv_d       = pinv_q;
    pjmp_d       = pjmp_q;
    paddr_d      = paddr_q;
    dout_valid_d = 1'b0;
    if (state_q == IDLE) begin
      valid_d = valid_q & ~inv_mask;
      if (lookup && hit) begin
        dout_valid_d = 1'b1;
        pjmp_d       = 1'b0;
      end else if (lookup) begin
        state_d = REFILL;
        cnt_d   = '0;
        line_d  = fa[ADDR_W-1:2+WB];
        pjmp_d  = jmp || pjmp_q;
        paddr_d = fa;
      end
    end else begin
      // Invalidates seen while busy are deferred so the finished refill cannot resurrect them.
      pinv_d = pinv_q | inv_mask;
      if (jmp) begin
        pjmp_d  = 1'b1;
        paddr_d = jmp_addr;
      end
      if (fill) cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d        = REPLAY;
        valid_d[r_idx] = 1'b1;
      end
      if (state_q != REFILL) begin
        state_d = IDLE;
        valid_d = valid_q & ~(pinv_q | inv_mask);
        pinv_d  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      valid_q      <= '0;
      pinv_q       <= '0;
      pjmp_q       <= 1'b0;
      paddr_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      pinv_q       <= pinv_d;
      pjmp_q       <= pjmp_d;
      paddr_q      <= paddr_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (last) tags[r_idx] <= line_q[LA_W-1 -: TAG_W];
  end
  icache_data_ram #(.DEPTH(LINES*WORDS), .DATA_W(DATA_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fill),
    .waddr ({r_idx, cnt_q}),
    .wdata (mem_data),
    .re    (lookup && hit),
    .raddr ({f_idx, f_word}),
    .rdata (dout)
  );
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: randomized self-checking bench against a line/tag reference model
module tb_icache_param;
  logic clk = 0, rst_n = 0, sel = 0;
  logic req = 0, jmp = 0, mem_ack = 0, inv = 0, flush = 0;
  logic [23:0] addr = 0, jmp_addr = 0, inv_addr = 0;
  logic [31:0] mem_data = 0;
  logic m_stall, m_dv, m_mem_req, p_stall, p_dv, p_mem_req;
  logic [31:0] m_dout, p_dout;
  logic [23:0] m_mem_addr;
  logic [15:0] p_mem_addr;
  logic s_stall, s_dv, s_mem_req;
  logic [31:0] s_dout;
  logic [23:0] s_mem_addr;
  int errs = 0, checks = 0;
  bit mv [2][16];
  int mt [2][16];
  always #5 clk = ~clk;
  icache_param dut (
    .clk(clk), .rst_n(rst_n), .req(req & ~sel), .addr(addr), .jmp(jmp & ~sel), .jmp_addr(jmp_addr),
    .dout(m_dout), .dout_valid(m_dv), .stall(m_stall), .mem_req(m_mem_req), .mem_addr(m_mem_addr),
    .mem_ack(mem_ack & ~sel), .mem_data(mem_data), .inv(inv & ~sel), .inv_addr(inv_addr), .flush(flush & ~sel)
  );
  icache_param #(.ADDR_W(16), .LINES(4), .WORDS(8)) dut_p (
    .clk(clk), .rst_n(rst_n), .req(req & sel), .addr(addr[15:0]), .jmp(jmp & sel), .jmp_addr(jmp_addr[15:0]),
    .dout(p_dout), .dout_valid(p_dv), .stall(p_stall), .mem_req(p_mem_req), .mem_addr(p_mem_addr),
    .mem_ack(mem_ack & sel), .mem_data(mem_data), .inv(inv & sel), .inv_addr(inv_addr[15:0]), .flush(flush & sel)
  );
  assign s_stall    = sel ? p_stall : m_stall;
  assign s_dv       = sel ? p_dv : m_dv;
  assign s_mem_req  = sel ? p_mem_req : m_mem_req;
  assign s_dout     = sel ? p_dout : m_dout;
  assign s_mem_addr = sel ? {8'h00, p_mem_addr} : m_mem_addr;
  function automatic int wn(); return sel ? 8 : 16; endfunction
  function automatic int ln(); return sel ? 4 : 16; endfunction
  function automatic int line_of(int a); return (a / (4 * wn())) % ln(); endfunction
  function automatic int tag_of(int a); return a / (4 * wn() * ln()); endfunction
  function automatic logic [31:0] mem_word(int a); return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D; endfunction
  function automatic bit m_hit(int a); return mv[int'(sel)][line_of(a)] && mt[int'(sel)][line_of(a)] == tag_of(a); endfunction
  task automatic m_fill(int a);
    mv[int'(sel)][line_of(a)] = 1;
    mt[int'(sel)][line_of(a)] = tag_of(a);
  endtask
  task automatic m_clear(int s);
    for (int i = 0; i < 16; i++) mv[s][i] = 0;
  endtask
  // Serves one line refill with random ack gaps; optional redirect/invalidate at a given ack
  // number, or a reset after rst_k acks.
  task automatic refill(input int base, input int jmp_k, input int jmp_a, input int inv_k, input int inv_a, input int rst_k);
    int k = 0, cyc = 0;
    while (k < wn() && cyc < 400) begin
      @(negedge clk);
      cyc++;
      jmp = 0; inv = 0; flush = 0;
      if (k == rst_k) begin
        req = 0; mem_ack = 0; rst_n = 0;
        #1;
        checks++;
        if ({s_mem_req, s_stall, s_dv} !== 3'b000 || s_dout !== 32'h0) begin
          errs++;
          $display("FAIL reset_mid: mem_req/stall/dv=%b dout=%h, required 000 and 0", {s_mem_req, s_stall, s_dv}, s_dout);
        end
        m_clear(0); m_clear(1);
        @(negedge clk);
        rst_n = 1;
        return;
      end
      checks++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== 24'(base + 4 * k)) begin
        errs++;
        $display("FAIL refill_addr: mem_req=%b mem_addr=%h, required 1 and %h", s_mem_req, s_mem_addr, 24'(base + 4 * k));
      end
      mem_ack = $urandom_range(0, 2) != 0;
      mem_data = mem_ack ? mem_word(base + 4 * k) : $urandom;
      if (mem_ack && k == jmp_k) begin jmp = 1; jmp_addr = 24'(jmp_a); end
      if (mem_ack && k == inv_k) begin inv = 1; inv_addr = 24'(inv_a); end
      if (mem_ack) k++;
    end
    if (k < wn()) begin
      checks++; errs++;
      $display("FAIL refill_timeout: acks=%0d, required %0d", k, wn());
    end
    @(negedge clk);
    jmp = 0; inv = 0;
    mem_ack = 1; mem_data = $urandom;
    checks++;
    if ({s_stall, s_mem_req, s_dv} !== 3'b100) begin
      errs++;
      $display("FAIL replay: stall/mem_req/dv=%b, required 100", {s_stall, s_mem_req, s_dv});
    end
    @(posedge clk);
    #1 mem_ack = 0;
  endtask
  task automatic access(input int a);
    bit h;
    @(negedge clk);
    req = 1; addr = 24'(a);
    #1;
    h = m_hit(a);
    checks++;
    if (s_stall !== !h) begin errs++; $display("FAIL lookup_stall @%h: stall=%b, required %b", a, s_stall, !h); end
    if (!h) begin
      refill(a - a % (4 * wn()), -1, 0, -1, 0, -1);
      m_fill(a);
      @(negedge clk);
      #1;
      checks++;
      if (s_stall !== 1'b0) begin errs++; $display("FAIL replay_hit @%h: stall=%b, required 0", a, s_stall); end
    end
    @(negedge clk);
    req = 0;
    checks++;
    if (s_dv !== 1'b1 || s_dout !== mem_word(a - a % 4)) begin
      errs++;
      $display("FAIL hit_data @%h: dv=%b dout=%h, required 1 and %h", a, s_dv, s_dout, mem_word(a - a % 4));
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_stall, m_dv, m_mem_req, p_stall, p_dv, p_mem_req} !== 6'b0 || m_dout !== 0 || p_dout !== 0) begin
      errs++;
      $display("FAIL reset: flags=%b dout=%h/%h, required 000000 and 0", {m_stall, m_dv, m_mem_req, p_stall, p_dv, p_mem_req}, m_dout, p_dout);
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_stream();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (s_dv !== 1'b1 || s_dout !== mem_word(32'h40 + 4 * (i - 1))) begin
          errs++;
          $display("FAIL stream[%0d]: dv=%b dout=%h, required 1 and %h", i - 1, s_dv, s_dout, mem_word(32'h40 + 4 * (i - 1)));
        end
      end
      if (i < 16) begin
        req = 1; addr = 24'(32'h40 + 4 * i);
        #1;
        checks++;
        if (s_stall !== 1'b0) begin errs++; $display("FAIL stream_stall[%0d]: stall=%b, required 0", i, s_stall); end
      end else req = 0;
    end
    @(negedge clk);
    checks++;
    if (s_dv !== 1'b0 || s_dout !== mem_word(32'h7C)) begin
      errs++;
      $display("FAIL idle_hold: dv=%b dout=%h, required 0 and %h", s_dv, s_dout, mem_word(32'h7C));
    end
  endtask
  task automatic test_redirect();
    @(negedge clk);
    req = 1; addr = 24'h100;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL redir_miss: stall=%b, required 1", s_stall); end
    refill(32'h100, 5, 32'h400, -1, 0, -1);
    m_fill(32'h100);
    @(negedge clk);
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL redir_target_miss: stall=%b, required 1", s_stall); end
    refill(32'h400, -1, 0, -1, 0, -1);
    m_fill(32'h400);
    @(negedge clk);
    #1;
    checks++;
    if (s_stall !== 1'b0) begin errs++; $display("FAIL redir_target_hit: stall=%b, required 0", s_stall); end
    @(negedge clk);
    checks++;
    if (s_dv !== 1'b1 || s_dout !== mem_word(32'h400)) begin
      errs++;
      $display("FAIL redir_data: dv=%b dout=%h, required 1 and %h", s_dv, s_dout, mem_word(32'h400));
    end
    #1;
    checks++;
    if (s_stall !== 1'b0) begin errs++; $display("FAIL redir_orig_hit: stall=%b, required 0", s_stall); end
    @(negedge clk);
    req = 0;
    checks++;
    if (s_dv !== 1'b1 || s_dout !== mem_word(32'h100)) begin
      errs++;
      $display("FAIL redir_orig_data: dv=%b dout=%h, required 1 and %h", s_dv, s_dout, mem_word(32'h100));
    end
  endtask
  task automatic test_inv_race();
    @(negedge clk);
    req = 1; addr = 24'h440;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL inv_race_miss: stall=%b, required 1", s_stall); end
    refill(32'h440, -1, 0, 3, 32'h40, -1);
    mv[0][1] = 0;
    @(negedge clk);
    addr = 24'h40;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL inv_race_refetch: stall=%b, required 1", s_stall); end
    refill(32'h40, -1, 0, -1, 0, -1);
    m_fill(32'h40);
    @(negedge clk);
    #1;
    checks++;
    if (s_stall !== 1'b0) begin errs++; $display("FAIL inv_race_hit: stall=%b, required 0", s_stall); end
    @(negedge clk);
    req = 0;
    checks++;
    if (s_dout !== mem_word(32'h40)) begin errs++; $display("FAIL inv_race_data: dout=%h, required %h", s_dout, mem_word(32'h40)); end
  endtask
  task automatic test_flush();
    @(negedge clk);
    req = 1; addr = 24'h44; flush = 1;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL flush_same_cycle: stall=%b, required 1", s_stall); end
    m_clear(0);
    refill(32'h40, -1, 0, -1, 0, -1);
    m_fill(32'h40);
    @(negedge clk);
    #1;
    @(negedge clk);
    req = 0;
    checks++;
    if (s_dv !== 1'b1 || s_dout !== mem_word(32'h44)) begin
      errs++;
      $display("FAIL flush_refill_data: dv=%b dout=%h, required 1 and %h", s_dv, s_dout, mem_word(32'h44));
    end
    access(32'h100);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    req = 1; addr = 24'h800;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin errs++; $display("FAIL reset_mid_miss: stall=%b, required 1", s_stall); end
    refill(32'h800, -1, 0, -1, 0, 7);
    access(32'h800);
  endtask
  task automatic test_random();
    int a, prev;
    prev = 32'h800;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (s_dv !== 1'b0 || s_dout !== mem_word(prev)) begin
        errs++;
        $display("FAIL rand_idle[%0d]: dv=%b dout=%h, required 0 and %h", i, s_dv, s_dout, mem_word(prev));
      end
      a = $urandom_range(0, 3) * 1024 + $urandom_range(0, 255) * 4;
      access(a);
      prev = a;
    end
  endtask
  task automatic test_param_sweep();
    int seq [10] = '{32'h0, 32'h4, 32'h80, 32'h0, 32'h8000, 32'h1C, 32'h0, 32'h60, 32'h8004, 32'h80E0};
    @(negedge clk);
    sel = 1;
    foreach (seq[i]) access(seq[i]);
    sel = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    access(32'h40);
    test_stream();
    test_redirect();
    test_inv_race();
    test_flush();
    test_reset_mid();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
